// File: rtl/radio_pll_responder.sv
// Radio-domain responder for the timing-engine PLL/RX handshake: models PLL settle
// and RX ramp delays, reports lock, the tArstFs timer-reset pulse, RX readiness and misuse.
module radio_pll_responder #(
   parameter int SETTLE_CYCLES = 16,
   parameter int RXRAMP_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic ck,
   input  logic arst,
   input  logic isolateIn,
   input  logic radioEnable,
   input  logic radioRxEn,
   output logic pllSettled,
   output logic tArstFs,
   output logic rxReady,
   output logic rxErr
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_LOCKED = 3'd2,
      ST_RAMP   = 3'd3,
      ST_RX     = 3'd4
   } state_t;

   // Counter load values: the state is left on the edge after the counter reads zero.
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RXRAMP_LOAD = CNT_W'(RXRAMP_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pll_q, pll_d;
   logic             tarst_q, tarst_d;
   logic             ready_q, ready_d;
   logic             err_q, err_d;

   // Isolation clamps both requests so a powered-down requester reads as idle.
   logic en, rx;
   assign en = radioEnable & ~isolateIn;
   assign rx = radioRxEn & ~isolateIn;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d = ST_SETTLE;
               cnt_d   = SETTLE_LOAD;
            end
         end
         ST_SETTLE: begin
            if (!en) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = ST_LOCKED;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_LOCKED: begin
            if (!en) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (rx) begin
               state_d = ST_RAMP;
               cnt_d   = RXRAMP_LOAD;
            end
         end
         ST_RAMP: begin
            if (!en) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (!rx) begin
               state_d = ST_LOCKED;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = ST_RX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RX: begin
            if (!en) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (!rx) begin
               state_d = ST_LOCKED;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the FSM.
   always_comb begin
      pll_d   = (state_d == ST_LOCKED) || (state_d == ST_RAMP) || (state_d == ST_RX);
      ready_d = (state_d == ST_RX);
      tarst_d = (state_q == ST_SETTLE) && (state_d == ST_LOCKED);
      err_d   = err_q | (rx & ((state_q == ST_IDLE) || (state_q == ST_SETTLE)));
   end

   always_ff @(posedge ck) begin
      if (arst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pll_q   <= 1'b0;
         tarst_q <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pll_q   <= pll_d;
         tarst_q <= tarst_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   assign pllSettled = pll_q;
   assign tArstFs    = tarst_q;
   assign rxReady    = ready_q;
   assign rxErr      = err_q;

endmodule
